data_bus_ram: RTL and testbench



---
 rtl/data_bus_ram.sv | 139 +++++++++++++
 tb/tb_data_bus_ram.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/data_bus_ram.sv
// rtl/data_bus_ram.sv - data bus responder RAM with programmable response latency
module data_bus_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_MASK = 32'(DEPTH_WORDS * 4 - 1);
    localparam logic [3:0]  LAT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic        capture;

    logic [31:0] addr_q;
    logic [31:0] value_q;
    logic [3:0]  mask_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Address/op of the request heading into RESPOND; with zero latency
    // that transition happens on the sampling edge, before the latch holds it.
    logic [31:0]      req_addr;
    logic             req_rd;
    logic             req_in_range;
    logic [IDX_W-1:0] req_idx;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (read_in || write_in) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = RESPOND;
                    end else begin
                        state_next = WAIT;
                        count_next = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Initiator withdrew the request: drop it silently.
                if (!(read_in || write_in)) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count == 4'd0) begin
                    state_next = RESPOND;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    always_comb begin
        req_addr     = capture ? address_in : addr_q;
        req_rd       = capture ? read_in : rd_q;
        req_in_range = (req_addr & ~SPAN_MASK) == BASE_ADDR;
        req_idx      = req_addr[IDX_W+1:2];
        wr_in_range  = (addr_q & ~SPAN_MASK) == BASE_ADDR;
        wr_idx       = addr_q[IDX_W+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= 4'd0;
            ready_out      <= 1'b0;
            read_value_out <= 32'h0000_0000;
            addr_q         <= 32'h0000_0000;
            value_q        <= 32'h0000_0000;
            mask_q         <= 4'h0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            ready_out <= (state_next == RESPOND);
            if (capture) begin
                addr_q  <= address_in;
                value_q <= write_value_in;
                mask_q  <= write_mask_in;
                rd_q    <= read_in;
                wr_q    <= write_in;
            end
            // Read data is captured before the RESPOND-ending write, giving
            // pre-write data on read-modify-write.
            if (state_next == RESPOND && req_rd) begin
                read_value_out <= req_in_range ? mem[req_idx] : 32'h0000_0000;
            end
        end
    end

    // Array deliberately has no reset; state being forced to IDLE by reset
    // is what cancels a pending write.
    always_ff @(posedge clk) begin
        if (state == RESPOND && wr_q && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem[wr_idx][8*b +: 8] <= value_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_ram.sv
// tb/tb_data_bus_ram.sv - scoreboard bench for data_bus_ram at latencies 1, 4, 0 and 15
module tb_data_bus_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr  [4];
    logic        rd    [4];
    logic        wr    [4];
    logic [3:0]  mask  [4];
    logic [31:0] wval  [4];
    logic [31:0] rval  [4];
    logic        rdy   [4];

    int          lat_of [4] = '{1, 4, 0, 15};
    logic [31:0] mdl    [4][1024];
    logic [31:0] last_rd [4];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    data_bus_ram #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .address_in(addr[0]), .read_in(rd[0]), .write_in(wr[0]),
        .write_mask_in(mask[0]), .write_value_in(wval[0]), .read_value_out(rval[0]), .ready_out(rdy[0]));
    data_bus_ram #(.LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .address_in(addr[1]), .read_in(rd[1]), .write_in(wr[1]),
        .write_mask_in(mask[1]), .write_value_in(wval[1]), .read_value_out(rval[1]), .ready_out(rdy[1]));
    data_bus_ram #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .address_in(addr[2]), .read_in(rd[2]), .write_in(wr[2]),
        .write_mask_in(mask[2]), .write_value_in(wval[2]), .read_value_out(rval[2]), .ready_out(rdy[2]));
    data_bus_ram #(.LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .address_in(addr[3]), .read_in(rd[3]), .write_in(wr[3]),
        .write_mask_in(mask[3]), .write_value_in(wval[3]), .read_value_out(rval[3]), .ready_out(rdy[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One full bus transaction on DUT d; expectations come from the model.
    task automatic req(input int d, input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] m, input logic [31:0] v);
        logic [31:0] old;
        logic        inr;
        int          cycles;
        inr = (a < 32'h1000);
        old = inr ? mdl[d][a[11:2]] : 32'h0;
        if (r) exp_q.push_back(old);
        if (w && inr) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) mdl[d][a[11:2]][8*b +: 8] = v[8*b +: 8];
        end
        @(negedge clk);
        addr[d] = a; rd[d] = r; wr[d] = w; mask[d] = m; wval[d] = v;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!rdy[d] && cycles < 40);
        check($sformatf("latency_d%0d", d), 32'(cycles), 32'(lat_of[d] + 1));
        if (r) begin
            last_rd[d] = exp_q.pop_front();
            check($sformatf("rdata_d%0d_%h", d, a), rval[d], last_rd[d]);
        end else begin
            check($sformatf("rdata_hold_d%0d", d), rval[d], last_rd[d]);
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("ready_single_d%0d", d), 32'(rdy[d]), 32'h0);
    endtask

    // Write to 0x40 on the LATENCY=4 DUT, then withdraw it or reset mid-WAIT.
    task automatic cancel_in_wait(input bit use_reset);
        int pulses;
        @(negedge clk);
        addr[1] = 32'h40; rd[1] = 1'b0; wr[1] = 1'b1; mask[1] = 4'hF; wval[1] = 32'h2222_2222;
        repeat (3) @(posedge clk);
        #1;
        if (use_reset) begin
            reset = 1'b0;
            #1;
            check("reset_rdata", rval[1], 32'h0);
            for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        end
        wr[1] = 1'b0;
        if (use_reset) begin
            @(negedge clk);
            reset = 1'b1;
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rdy[1]) pulses++;
        end
        check(use_reset ? "no_ready_reset" : "no_ready_abort", 32'(pulses), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; mask[i] = '0; wval[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_ready_d%0d", i), 32'(rdy[i]), 32'h0);
            check($sformatf("reset_rval_d%0d", i), rval[i], 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        // LATENCY=1: full, partial and empty-mask writes
        req(0, 32'h10, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        req(0, 32'h10, 1'b1, 1'b0, 4'b0000, 32'h0);
        req(0, 32'h10, 1'b0, 1'b1, 4'b0011, 32'h0000_1122);
        req(0, 32'h10, 1'b1, 1'b0, 4'b0000, 32'h0);
        check("partial_const", last_rd[0], 32'hDEAD_1122);
        req(0, 32'h10, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        req(0, 32'h10, 1'b1, 1'b0, 4'b0000, 32'h0);

        // read-modify-write
        req(0, 32'h20, 1'b0, 1'b1, 4'b1111, 32'h1234_5678);
        req(0, 32'h20, 1'b1, 1'b1, 4'b1100, 32'hAABB_CCDD);
        check("rmw_const", rval[0], 32'h1234_5678);
        req(0, 32'h20, 1'b1, 1'b0, 4'b0000, 32'h0);
        check("rmw_after_const", last_rd[0], 32'hAABB_5678);

        // out of range and address LSBs ignored
        req(0, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h0BAD_F00D);
        req(0, 32'h1000, 1'b0, 1'b1, 4'b1111, 32'hFFFF_FFFF);
        req(0, 32'h1000, 1'b1, 1'b0, 4'b0000, 32'h0);
        req(0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        req(0, 32'h13, 1'b1, 1'b0, 4'b0000, 32'h0);

        // latency extremes
        req(2, 32'h8, 1'b0, 1'b1, 4'b1111, 32'hCAFE_0001);
        req(2, 32'h8, 1'b1, 1'b0, 4'b0000, 32'h0);
        req(2, 32'h8, 1'b1, 1'b1, 4'b0101, 32'h1111_1111);
        req(3, 32'hFFC, 1'b0, 1'b1, 4'b1111, 32'h5A5A_A5A5);
        req(3, 32'hFFC, 1'b1, 1'b0, 4'b0000, 32'h0);

        // abort and reset while in WAIT
        req(1, 32'h40, 1'b0, 1'b1, 4'b1111, 32'h1111_1111);
        cancel_in_wait(1'b0);
        req(1, 32'h40, 1'b1, 1'b0, 4'b0000, 32'h0);
        cancel_in_wait(1'b1);
        req(1, 32'h40, 1'b1, 1'b0, 4'b0000, 32'h0);
        check("cancel_word_const", last_rd[1], 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
